// File: rtl/dispenser_rolhas_param.sv
// Cork dispenser controller: tracks magazine stock, times the dispense actuator,
// and counts corks during refill.
module dispenser_rolhas_param #(
  parameter int unsigned CAPACITY    = 15,
  parameter int unsigned LOW_LEVEL   = 5,
  parameter int unsigned DISP_CYCLES = 3,
  parameter int unsigned INIT_COUNT  = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_req,
  input  logic             add_mode,
  input  logic             add_pulse,
  output logic             disp,
  output logic             add_rolha,
  output logic             disp_ack,
  output logic             err_empty,
  output logic [CNT_W-1:0] count,
  output logic             low,
  output logic             empty,
  output logic             full
);

  // state  | meaning
  // S_IDLE | waiting; refill has priority over a dispense request
  // S_DISP | actuator on, timer counting down to zero
  // S_DONE | one-cycle acknowledge after the cork left
  // S_ADD  | refill gate open, counting inserted corks
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DISP = 2'd1,
    S_DONE = 2'd2,
    S_ADD  = 2'd3
  } state_t;

  localparam int unsigned TMR_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_LEVEL);
  localparam logic [CNT_W-1:0] INIT_C  = CNT_W'(INIT_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TMR_W-1:0] TMR_LD  = TMR_W'(DISP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             add_pulse_q;
  logic             disp_q, ack_q, add_q;
  logic             pulse_edge;

  assign pulse_edge = add_pulse & ~add_pulse_q;

  assign empty = (count_q == '0);
  assign full  = (count_q == CAP_C);
  assign low   = (count_q <= LOW_C);
  assign count = count_q;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (add_mode) begin
          state_d = S_ADD;
        end else if (disp_req && !empty) begin
          state_d = S_DISP;
          timer_d = TMR_LD;
        end
      end
      S_DISP: begin
        if (timer_q == '0) begin
          state_d = S_DONE;
          if (!empty) count_d = count_q - CNT_ONE;
        end else begin
          timer_d = timer_q - TMR_ONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ADD: begin
        // an edge in the cycle add_mode drops is still counted
        if (pulse_edge && !full) count_d = count_q + CNT_ONE;
        if (!add_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      count_q     <= INIT_C;
      add_pulse_q <= 1'b0;
      disp_q      <= 1'b0;
      ack_q       <= 1'b0;
      add_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      count_q     <= count_d;
      add_pulse_q <= add_pulse;
      disp_q      <= (state_d == S_DISP);
      ack_q       <= (state_d == S_DONE);
      add_q       <= (state_d == S_ADD);
    end
  end

  assign disp      = disp_q;
  assign disp_ack  = ack_q;
  assign add_rolha = add_q & ~full;
  assign err_empty = (state_q == S_IDLE) & disp_req & ~add_mode & empty;

endmodule

// File: tb/tb_dispenser_rolhas_param.sv
// Directed bench for dispenser_rolhas_param with default parameters.
module tb_dispenser_rolhas_param;

  logic       clk = 1'b0;
  logic       reset, disp_req, add_mode, add_pulse;
  logic       disp, add_rolha, disp_ack, err_empty, low, empty, full;
  logic [3:0] count;

  int n_vec = 0;
  int n_err = 0;

  dispenser_rolhas_param dut (
    .clk       (clk),
    .reset     (reset),
    .disp_req  (disp_req),
    .add_mode  (add_mode),
    .add_pulse (add_pulse),
    .disp      (disp),
    .add_rolha (add_rolha),
    .disp_ack  (disp_ack),
    .err_empty (err_empty),
    .count     (count),
    .low       (low),
    .empty     (empty),
    .full      (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; disp_req = 1'b0; add_mode = 1'b0; add_pulse = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_low", int'(low), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_disp", int'(disp), 0);
    chk("rst_add_rolha", int'(add_rolha), 0);
    chk("rst_ack", int'(disp_ack), 0);
    chk("rst_err", int'(err_empty), 0);

    // requests on an empty magazine are refused
    disp_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("empty_err", int'(err_empty), 1);
      chk("empty_disp", int'(disp), 0);
      chk("empty_count", int'(count), 0);
      cyc();
    end
    disp_req = 1'b0;
    #1;
    chk("empty_err_off", int'(err_empty), 0);

    // refill with 16 pulses, the last one beyond capacity
    add_mode = 1'b1;
    cyc();
    chk("add_gate_open", int'(add_rolha), 1);
    for (int p = 1; p <= 16; p++) begin
      add_pulse = 1'b1;
      cyc();
      chk("fill_count", int'(count), (p < 15) ? p : 15);
      chk("fill_full", int'(full), (p >= 15) ? 1 : 0);
      chk("fill_gate", int'(add_rolha), (p < 15) ? 1 : 0);
      chk("fill_low", int'(low), (p <= 5) ? 1 : 0);
      cyc();
      add_pulse = 1'b0;
      cyc(); cyc();
    end
    add_mode = 1'b0;
    cyc();

    // single dispense from full: disp n+1..n+3, ack and count in n+4
    disp_req = 1'b1;
    cyc();
    disp_req = 1'b0;
    chk("one_disp1", int'(disp), 1);
    chk("one_cnt_hold", int'(count), 15);
    cyc();
    chk("one_disp2", int'(disp), 1);
    cyc();
    chk("one_disp3", int'(disp), 1);
    chk("one_noack", int'(disp_ack), 0);
    cyc();
    chk("one_disp_off", int'(disp), 0);
    chk("one_ack", int'(disp_ack), 1);
    chk("one_count", int'(count), 14);
    chk("one_full", int'(full), 0);
    cyc();
    chk("one_ack_off", int'(disp_ack), 0);

    // held request drains the magazine, one cork every 5 cycles
    disp_req = 1'b1;
    for (int d = 1; d <= 14; d++) begin
      #1;
      chk("hold_idle_disp", int'(disp), 0);
      chk("hold_idle_err", int'(err_empty), 0);
      cyc();
      for (int j = 0; j < 3; j++) begin
        chk("hold_disp", int'(disp), 1);
        cyc();
      end
      chk("hold_ack", int'(disp_ack), 1);
      chk("hold_count", int'(count), 14 - d);
      chk("hold_low", int'(low), (14 - d <= 5) ? 1 : 0);
      chk("hold_empty", int'(empty), (d == 14) ? 1 : 0);
      cyc();
    end
    #1;
    chk("drain_err", int'(err_empty), 1);
    chk("drain_disp", int'(disp), 0);
    cyc();
    chk("drain_err2", int'(err_empty), 1);
    chk("drain_disp2", int'(disp), 0);

    // simultaneous request and refill: refill wins
    add_mode = 1'b1;
    #1;
    chk("sim_err", int'(err_empty), 0);
    cyc();
    chk("sim_disp", int'(disp), 0);
    chk("sim_gate", int'(add_rolha), 1);
    for (int p = 1; p <= 9; p++) begin
      add_pulse = 1'b1;
      cyc();
      add_pulse = 1'b0;
      chk("sim_count", int'(count), p);
      chk("sim_nodisp", int'(disp), 0);
      cyc();
    end

    // add_mode raised mid-dispense: dispense completes, then refill
    add_mode = 1'b0;
    cyc();
    chk("mid_idle_disp", int'(disp), 0);
    cyc();
    add_mode = 1'b1;
    disp_req = 1'b0;
    chk("mid_disp1", int'(disp), 1);
    cyc();
    chk("mid_disp2", int'(disp), 1);
    cyc();
    chk("mid_disp3", int'(disp), 1);
    chk("mid_gate_closed", int'(add_rolha), 0);
    cyc();
    chk("mid_ack", int'(disp_ack), 1);
    chk("mid_count", int'(count), 8);
    cyc();
    chk("mid_idle_gate", int'(add_rolha), 0);
    chk("mid_idle_disp2", int'(disp), 0);
    cyc();
    chk("mid_add_gate", int'(add_rolha), 1);
    add_pulse = 1'b1;
    cyc();
    add_pulse = 1'b0;
    chk("mid_refill", int'(count), 9);
    cyc();

    // reset in the 2nd dispense cycle aborts without ack or decrement
    add_mode = 1'b0;
    cyc();
    disp_req = 1'b1;
    cyc();
    disp_req = 1'b0;
    chk("rd_disp1", int'(disp), 1);
    cyc();
    chk("rd_disp2", int'(disp), 1);
    reset = 1'b1;
    add_pulse = 1'b1;
    cyc();
    chk("rd_disp_off", int'(disp), 0);
    chk("rd_count", int'(count), 0);
    chk("rd_ack", int'(disp_ack), 0);
    chk("rd_empty", int'(empty), 1);
    reset = 1'b0;
    cyc();
    chk("rd_ack2", int'(disp_ack), 0);
    chk("rd_count2", int'(count), 0);
    chk("rd_disp2_off", int'(disp), 0);
    add_mode = 1'b1;
    cyc();
    chk("rd_gate", int'(add_rolha), 1);
    chk("rd_held_pulse", int'(count), 0);
    cyc();
    chk("rd_held_pulse2", int'(count), 0);
    add_pulse = 1'b0;
    cyc();
    add_pulse = 1'b1;
    cyc();
    chk("rd_new_pulse", int'(count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
